// File: rtl/v_hier_pkg.sv
`default_nettype none
// ============================================================================
// Package : v_hier_pkg
// Purpose : Shared widths and types for the v_hier nibble-packing stage.
//           NIBBLE_W / NIBBLES_PER_WORD / WORD_W fix the packing geometry;
//           nibble_t and word_t are the matching vector types.
// Revision: 1.0 - initial release
// ============================================================================
package v_hier_pkg;

  localparam int NIBBLE_W         = 4;
  localparam int NIBBLES_PER_WORD = 4;
  localparam int WORD_W           = NIBBLE_W * NIBBLES_PER_WORD;

  typedef logic [NIBBLE_W-1:0] nibble_t;
  typedef logic [WORD_W-1:0]   word_t;

endpackage
`default_nettype wire

// File: rtl/v_hier_qpack_fifo.sv
`default_nettype none
// ============================================================================
// Module  : v_hier_qpack_fifo
// Purpose : Synchronous FIFO, DEPTH entries of WIDTH bits, registered storage
//           with a combinational head read. Pointers carry one extra bit so
//           that full and empty can be told apart.
// Ports   : clk, rst (async, active-high)
//           push, wdata  - write side (ignored when full without a pop)
//           pop          - advance head (ignored when empty)
//           rdata        - storage entry at the read pointer
//           full, empty  - occupancy flags
// Revision: 1.0 - initial release
// ============================================================================
module v_hier_qpack_fifo
  import v_hier_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  // A push into a full FIFO is allowed when the head leaves in the same cycle:
  // the slot being written is the one being vacated.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr              <= wptr + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop) begin
        rptr <= rptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/v_hier_qpack.sv
`default_nettype none
// ============================================================================
// Module  : v_hier_qpack
// Purpose : Packs four accepted 4-bit qvec nibbles into a 16-bit word (first
//           nibble in bits [3:0]) and queues completed words in a FIFO that
//           drains over valid/ready. A flush pulse pushes a partial word
//           zero-padded in the upper nibbles.
// Ports   : clk, rst (async, active-high)
//           qvec, in_valid, in_ready   - nibble input handshake
//           flush                      - push the partial word
//           out_valid, out_data, out_ready - word output handshake
//           out_par                    - even parity of out_data
// Config  : V_HIER_QPACK_PARITY_EN - when defined, each FIFO entry carries a
//           parity bit and the out_par port exists.
// Revision: 1.0 - initial release
// ============================================================================
module v_hier_qpack
  import v_hier_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  qvec,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready
`ifdef V_HIER_QPACK_PARITY_EN
  ,
  output logic        out_par
`endif
);

`ifdef V_HIER_QPACK_PARITY_EN
  localparam int FIFO_W = WORD_W + 1;
`else
  localparam int FIFO_W = WORD_W;
`endif

  logic [1:0]  nib_cnt;
  logic [11:0] held;
  logic        flush_pend;

  logic        full;
  logic        empty;
  logic        pop;
  logic        space;
  logic        accept;
  logic        word_done;
  logic        flush_req;
  logic        flush_now;
  logic        push;
  word_t       push_word;
  logic [FIFO_W-1:0] wdata;
  logic [FIFO_W-1:0] rdata;
  nibble_t     nib;

  assign nib       = qvec;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  // Room for one more word this cycle, counting a same-cycle pop.
  assign space     = !full || pop;

  // A pending flush owns the next push slot, so new nibbles are held off.
  assign in_ready  = !flush_pend && ((nib_cnt != 2'd3) || space);
  assign accept    = in_valid && in_ready;
  assign word_done = accept && (nib_cnt == 2'd3);

  // A flush only acts in a cycle without an accepted nibble; a coincident
  // nibble wins and the flush is carried over via flush_pend.
  assign flush_req = flush || flush_pend;
  assign flush_now = flush_req && !accept && (nib_cnt != 2'd0) && space;

  assign push      = word_done || flush_now;
  // held is cleared after every push, so unfilled positions are already zero.
  assign push_word = word_done ? {nib, held} : {4'h0, held};

`ifdef V_HIER_QPACK_PARITY_EN
  assign wdata    = {^push_word, push_word};
  assign out_data = rdata[WORD_W-1:0];
  assign out_par  = rdata[WORD_W];
`else
  assign wdata    = push_word;
  assign out_data = rdata;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nib_cnt    <= 2'd0;
      held       <= 12'h000;
      flush_pend <= 1'b0;
    end else begin
      if (accept) begin
        if (nib_cnt == 2'd3) begin
          nib_cnt <= 2'd0;
          held    <= 12'h000;
        end else begin
          case (nib_cnt)
            2'd0:    held[3:0]  <= nib;
            2'd1:    held[7:4]  <= nib;
            default: held[11:8] <= nib;
          endcase
          nib_cnt <= nib_cnt + 2'd1;
        end
      end else if (flush_now) begin
        nib_cnt <= 2'd0;
        held    <= 12'h000;
      end

      if (accept) begin
        // Deferred flush only matters if nibbles remain after this accept.
        flush_pend <= flush && (nib_cnt != 2'd3);
      end else if (flush_req) begin
        flush_pend <= (nib_cnt != 2'd0) && !space;
      end
    end
  end

  v_hier_qpack_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_v_hier_qpack.sv
`default_nettype none
// ============================================================================
// Module  : tb_v_hier_qpack
// Purpose : Self-checking bench for v_hier_qpack (DEPTH=4). A queue-based
//           model of the packer/FIFO predicts in_ready, out_valid, out_data
//           (and out_par with V_HIER_QPACK_PARITY_EN) every cycle; directed
//           scenarios are followed by a randomized run.
// Revision: 1.0 - initial release
// ============================================================================
module tb_v_hier_qpack;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  qvec = 4'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready = 1'b0;
`ifdef V_HIER_QPACK_PARITY_EN
  logic        out_par;
`endif

  int checks   = 0;
  int failures = 0;

  // Model state: stored words, held nibbles (oldest first), pending flush.
  logic [15:0] mq[$];
  logic [3:0]  part[$];
  bit          pend = 1'b0;

  always #5 clk = ~clk;

  v_hier_qpack #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .qvec      (qvec),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef V_HIER_QPACK_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance the model to what the following edge should produce.
  task automatic step(input logic iv, input logic [3:0] nib, input logic fl, input logic ordy);
    bit          ev, full, pop, er, acc;
    logic [15:0] w;
    @(negedge clk);
    in_valid  = iv;
    qvec      = nib;
    flush     = fl;
    out_ready = ordy;
    #1;
    ev   = (mq.size() > 0);
    full = (mq.size() == DEPTH);
    pop  = ev && ordy;
    er   = !pend && ((part.size() != 3) || !full || pop);
    chk("in_ready", {15'd0, in_ready}, {15'd0, er});
    chk("out_valid", {15'd0, out_valid}, {15'd0, ev});
    if (ev) begin
      chk("out_data", out_data, mq[0]);
`ifdef V_HIER_QPACK_PARITY_EN
      chk("out_par", {15'd0, out_par}, {15'd0, ^mq[0]});
`endif
    end
    acc = iv && er;
    if (pop) void'(mq.pop_front());
    if (acc) begin
      part.push_back(nib);
      if (part.size() == 4) begin
        w = {part[3], part[2], part[1], part[0]};
        mq.push_back(w);
        part.delete();
        pend = 1'b0;
      end else begin
        pend = fl;
      end
    end else if (fl || pend) begin
      if (part.size() == 0) begin
        pend = 1'b0;
      end else if (!full || pop) begin
        w = 16'h0000;
        foreach (part[i]) w = w | (16'(part[i]) << (4 * i));
        mq.push_back(w);
        part.delete();
        pend = 1'b0;
      end else begin
        pend = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; qvec = 4'h0;
    #1;
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
    chk("rst_out_data", out_data, 16'h0000);
`ifdef V_HIER_QPACK_PARITY_EN
    chk("rst_out_par", {15'd0, out_par}, 16'd0);
`endif
    mq.delete();
    part.delete();
    pend = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] n;

    // 1: reset mid-word, then a clean word
    do_reset();
    step(1, 4'h7, 0, 1);
    step(1, 4'h9, 0, 1);
    do_reset();
    step(1, 4'h1, 0, 0);
    step(1, 4'h2, 0, 0);
    step(1, 4'h3, 0, 0);
    step(1, 4'h4, 0, 0);
    step(0, 4'h0, 0, 0);
    chk("t1_word", out_data, 16'h4321);
    step(0, 4'h0, 0, 1);
    step(0, 4'h0, 0, 0);
    chk("t1_empty", {15'd0, out_valid}, 16'd0);

    // 2: streaming word, held one cycle with out_ready=1
    step(1, 4'h1, 0, 1);
    step(1, 4'h2, 0, 1);
    step(1, 4'h3, 0, 1);
    step(1, 4'h4, 0, 1);
    chk("t2_not_yet", {15'd0, out_valid}, 16'd0);
    step(0, 4'h0, 0, 1);
    chk("t2_valid", {15'd0, out_valid}, 16'd1);
    chk("t2_word", out_data, 16'h4321);
    step(0, 4'h0, 0, 1);
    chk("t2_one_cycle", {15'd0, out_valid}, 16'd0);

    // 3: fill with 19 nibbles, stall, pulse out_ready, drain
    for (int i = 0; i < 19; i++) begin
      n = 4'(i * 3 + 1);
      step(1, n, 0, 0);
    end
    step(1, 4'hE, 0, 0);
    chk("t3_stall", {15'd0, in_ready}, 16'd0);
    step(1, 4'hE, 0, 1);
    chk("t3_pop_ready", {15'd0, in_ready}, 16'd1);
    for (int i = 0; i < 5; i++) step(0, 4'h0, 0, 1);

    // 4: partial flush, then a no-op flush
    step(1, 4'hA, 0, 1);
    step(1, 4'hB, 0, 1);
    step(0, 4'h0, 1, 1);
    step(0, 4'h0, 0, 0);
    chk("t4_padded", out_data, 16'h00BA);
    step(0, 4'h0, 0, 1);
    step(0, 4'h0, 1, 0);
    step(0, 4'h0, 0, 0);
    chk("t4_noop", {15'd0, out_valid}, 16'd0);

    // 5: flush with a full FIFO and three held nibbles
    for (int i = 0; i < 19; i++) begin
      n = 4'(i + 2);
      step(1, n, 0, 0);
    end
    step(0, 4'h0, 1, 0);
    step(1, 4'h5, 0, 0);
    chk("t5_pend_block", {15'd0, in_ready}, 16'd0);
    step(0, 4'h0, 0, 1);
    chk("t5_pend_pop", {15'd0, in_ready}, 16'd0);
    step(1, 4'h5, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 4'h0, 0, 1);
    chk("t5_drained", {15'd0, out_valid}, 16'd0);

    // flush coincident with an accepted nibble
    step(1, 4'hC, 1, 1);
    step(1, 4'hD, 0, 1);
    step(0, 4'h0, 0, 1);
    step(0, 4'h0, 0, 1);

`ifdef V_HIER_QPACK_PARITY_EN
    // 6: parity
    step(1, 4'h1, 0, 0);
    step(0, 4'h0, 1, 0);
    step(0, 4'h0, 0, 0);
    chk("t6_par1", {15'd0, out_par}, 16'd1);
    step(0, 4'h0, 0, 1);
    step(1, 4'h3, 0, 0);
    step(0, 4'h0, 1, 0);
    step(0, 4'h0, 0, 0);
    chk("t6_par0", {15'd0, out_par}, 16'd0);
    step(0, 4'h0, 0, 1);
`endif

    // randomized traffic with one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step(1'($urandom_range(1)), 4'($urandom), ($urandom_range(7) == 0),
           ($urandom_range(2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
